note_template_streamer: RTL and testbench

- Successor to the fixed two-entry note-length bitmap select in the match accelerator.
- Holds NUM_TEMPLATES writable MAP_H x MAP_W note-head/stem bitmaps, e.g. whole, half, quarter and eighth templates loaded by the host.
- On request, streams one selected template row-by-row over a valid/ready interface to the matcher datapath.
- Optional vertical flip streams rows bottom-up, for stem-down notes.

---
 rtl/note_template_streamer.sv | 147 ++++++++++++++
 tb/tb_note_template_streamer.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/note_template_streamer.sv
// Stores host-written note templates and streams one selected template row-by-row
// over valid/ready, optionally bottom-up for stem-down notes.
module note_template_streamer #(
  parameter int unsigned MAP_W         = 16,
  parameter int unsigned MAP_H         = 16,
  parameter int unsigned NUM_TEMPLATES = 4,
  parameter int unsigned SEL_W         = 2,
  parameter int unsigned ROW_W         = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [SEL_W-1:0] wr_tmpl,
  input  logic [ROW_W-1:0] wr_row,
  input  logic [MAP_W-1:0] wr_data,
  output logic             wr_err,
  input  logic             start,
  input  logic [SEL_W-1:0] sel,
  input  logic             flip,
  output logic             sel_err,
  output logic             busy,
  output logic             row_valid,
  input  logic             row_ready,
  output logic [MAP_W-1:0] row_data,
  output logic [ROW_W-1:0] row_idx,
  output logic             row_last,
  output logic             done
);

  localparam int unsigned Depth = NUM_TEMPLATES * MAP_H;
  localparam int unsigned AddrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam logic [ROW_W-1:0] LastRow = ROW_W'(MAP_H - 1);

  typedef enum logic [0:0] {StIdle, StStream} state_e;

  state_e state_q, state_d;

  logic [MAP_W-1:0] mem_q [Depth];
  logic [SEL_W-1:0] tmpl_q, tmpl_d;
  logic             flip_q, flip_d;
  logic             row_valid_q, row_valid_d;
  logic [MAP_W-1:0] row_data_q, row_data_d;
  logic [ROW_W-1:0] row_idx_q, row_idx_d;
  logic             row_last_q, row_last_d;
  logic             done_q, done_d;
  logic             wr_err_q, wr_err_d;
  logic             sel_err_q, sel_err_d;

  logic             sel_ok, launch, advance, finish, wr_bad, wr_ok;
  logic [ROW_W-1:0] first_row, next_row, final_row;

  function automatic logic [AddrW-1:0] addr(input logic [SEL_W-1:0] t,
                                            input logic [ROW_W-1:0] r);
    return AddrW'(32'(t) * MAP_H + 32'(r));
  endfunction

  assign sel_ok    = 32'(sel) < NUM_TEMPLATES;
  assign launch    = (state_q == StIdle) && start && sel_ok;
  assign advance   = (state_q == StStream) && row_valid_q && row_ready && !row_last_q;
  assign finish    = (state_q == StStream) && row_valid_q && row_ready && row_last_q;
  assign first_row = flip ? LastRow : '0;
  assign next_row  = flip_q ? row_idx_q - ROW_W'(1) : row_idx_q + ROW_W'(1);
  assign final_row = flip_q ? '0 : LastRow;

  // The streaming template is locked, including one being launched this cycle.
  assign wr_bad = wr_en && ((32'(wr_tmpl) >= NUM_TEMPLATES) || (32'(wr_row) >= MAP_H) ||
                            ((state_q == StStream) && (wr_tmpl == tmpl_q)) ||
                            (launch && (wr_tmpl == sel)));
  assign wr_ok  = wr_en && !wr_bad;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      tmpl_q      <= '0;
      flip_q      <= 1'b0;
      row_valid_q <= 1'b0;
      row_data_q  <= '0;
      row_idx_q   <= '0;
      row_last_q  <= 1'b0;
      done_q      <= 1'b0;
      wr_err_q    <= 1'b0;
      sel_err_q   <= 1'b0;
      for (int i = 0; i < int'(Depth); i++) mem_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      tmpl_q      <= tmpl_d;
      flip_q      <= flip_d;
      row_valid_q <= row_valid_d;
      row_data_q  <= row_data_d;
      row_idx_q   <= row_idx_d;
      row_last_q  <= row_last_d;
      done_q      <= done_d;
      wr_err_q    <= wr_err_d;
      sel_err_q   <= sel_err_d;
      if (wr_ok) mem_q[addr(wr_tmpl, wr_row)] <= wr_data;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (launch) state_d = StStream;
      StStream: if (finish) state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_comb begin
    tmpl_d      = tmpl_q;
    flip_d      = flip_q;
    row_valid_d = row_valid_q;
    row_data_d  = row_data_q;
    row_idx_d   = row_idx_q;
    row_last_d  = row_last_q;
    done_d      = 1'b0;
    wr_err_d    = wr_bad;
    sel_err_d   = (state_q == StIdle) && start && !sel_ok;
    if (launch) begin
      tmpl_d      = sel;
      flip_d      = flip;
      row_valid_d = 1'b1;
      row_idx_d   = first_row;
      row_data_d  = mem_q[addr(sel, first_row)];
      row_last_d  = (MAP_H == 1);
    end else if (advance) begin
      row_idx_d   = next_row;
      row_data_d  = mem_q[addr(tmpl_q, next_row)];
      row_last_d  = (next_row == final_row);
    end else if (finish) begin
      row_valid_d = 1'b0;
      row_data_d  = '0;
      row_idx_d   = '0;
      row_last_d  = 1'b0;
      done_d      = 1'b1;
    end
  end

  assign busy      = (state_q == StStream);
  assign row_valid = row_valid_q;
  assign row_data  = row_data_q;
  assign row_idx   = row_idx_q;
  assign row_last  = row_last_q;
  assign done      = done_q;
  assign wr_err    = wr_err_q;
  assign sel_err   = sel_err_q;

endmodule

// File: tb/tb_note_template_streamer.sv
// Directed bench for note_template_streamer: three templates, 16x16 maps, 5-bit row index
// so that out-of-range rows and templates can be presented.
module tb_note_template_streamer;

  logic        clk = 1'b0;
  logic        rst, wr_en, start, flip, row_ready;
  logic [1:0]  wr_tmpl, sel;
  logic [4:0]  wr_row;
  logic [15:0] wr_data;
  logic        wr_err, sel_err, busy, row_valid, row_last, done;
  logic [15:0] row_data;
  logic [4:0]  row_idx;

  int n_checks = 0;
  int n_errors = 0;
  logic [15:0] exp_rows [16];

  always #5 clk = ~clk;

  note_template_streamer #(
    .MAP_W(16), .MAP_H(16), .NUM_TEMPLATES(3), .SEL_W(2), .ROW_W(5)
  ) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_tmpl(wr_tmpl), .wr_row(wr_row),
    .wr_data(wr_data), .wr_err(wr_err), .start(start), .sel(sel), .flip(flip),
    .sel_err(sel_err), .busy(busy), .row_valid(row_valid), .row_ready(row_ready),
    .row_data(row_data), .row_idx(row_idx), .row_last(row_last), .done(done)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] abc_row(input int r);
    logic [3:0] nib;
    nib = r[3:0];
    return {nib, 12'hABC};
  endfunction

  // Unflipped stream with ready held high; expects exp_rows and checks done timing.
  task automatic run_stream(input logic [1:0] s);
    sel = s; flip = 1'b0; start = 1'b1; row_ready = 1'b1;
    tick();
    start = 1'b0;
    for (int r = 0; r < 16; r++) begin
      check("stream valid", row_valid, 1);
      check("stream busy", busy, 1);
      check("stream idx", row_idx, r);
      check("stream data", row_data, exp_rows[r]);
      check("stream last", row_last, (r == 15));
      check("stream no done", done, 0);
      tick();
    end
    check("stream done", done, 1);
    check("stream valid off", row_valid, 0);
    check("stream busy off", busy, 0);
    check("stream data zero", row_data, 0);
  endtask

  initial begin
    int exp_r, c;
    logic fin;
    rst = 1'b1; wr_en = 1'b0; wr_tmpl = '0; wr_row = '0; wr_data = '0;
    start = 1'b0; sel = '0; flip = 1'b0; row_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    check("reset valid", row_valid, 0);
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset wr_err", wr_err, 0);
    check("reset sel_err", sel_err, 0);
    check("reset data", row_data, 0);

    // Cleared template 0
    for (int r = 0; r < 16; r++) exp_rows[r] = '0;
    run_stream(2'd0);

    // Load template 1 and stream it
    for (int r = 0; r < 16; r++) begin
      wr_en = 1'b1; wr_tmpl = 2'd1; wr_row = 5'(r); wr_data = abc_row(r);
      tick();
      check("load wr_err", wr_err, 0);
    end
    wr_en = 1'b0;
    for (int r = 0; r < 16; r++) exp_rows[r] = abc_row(r);
    run_stream(2'd1);

    // Flipped with backpressure 1,0,0,1,0,0,...
    sel = 2'd1; flip = 1'b1; start = 1'b1; row_ready = 1'b0;
    tick();
    start = 1'b0; flip = 1'b0;
    exp_r = 15; c = 0; fin = 1'b0;
    while (!fin && c < 100) begin
      check("flip valid", row_valid, 1);
      check("flip idx", row_idx, exp_r);
      check("flip data", row_data, abc_row(exp_r));
      check("flip last", row_last, (exp_r == 0));
      row_ready = (c % 3 == 0);
      tick();
      if (row_ready) begin
        if (exp_r == 0) fin = 1'b1;
        else exp_r--;
      end
      c++;
    end
    check("flip finished", fin, 1);
    check("flip done", done, 1);
    check("flip busy off", busy, 0);

    // Write protection during a stream of template 1
    sel = 2'd1; flip = 1'b0; start = 1'b1; row_ready = 1'b1;
    tick();
    start = 1'b0;
    check("prot idx0", row_idx, 0);
    wr_en = 1'b1; wr_tmpl = 2'd1; wr_row = 5'd3; wr_data = 16'hFFFF;
    tick();
    check("prot locked wr_err", wr_err, 1);
    wr_tmpl = 2'd2; wr_data = 16'h1234;
    tick();
    wr_en = 1'b0;
    check("prot other wr_err", wr_err, 0);
    for (int r = 2; r < 16; r++) begin
      check("prot idx", row_idx, r);
      check("prot data", row_data, abc_row(r));
      tick();
    end
    check("prot done", done, 1);
    for (int r = 0; r < 16; r++) exp_rows[r] = '0;
    exp_rows[3] = 16'h1234;
    run_stream(2'd2);

    // Invalid requests and writes
    sel = 2'd3; start = 1'b1;
    tick();
    start = 1'b0;
    check("bad sel sel_err", sel_err, 1);
    check("bad sel busy", busy, 0);
    check("bad sel valid", row_valid, 0);
    wr_en = 1'b1; wr_tmpl = 2'd0; wr_row = 5'd16; wr_data = 16'hFFFF;
    tick();
    check("sel_err one pulse", sel_err, 0);
    check("bad row wr_err", wr_err, 1);
    wr_tmpl = 2'd3; wr_row = 5'd0;
    tick();
    check("bad tmpl wr_err", wr_err, 1);
    // Same-cycle start and write to the launched template: write rejected
    wr_tmpl = 2'd2; wr_row = 5'd0; sel = 2'd2; start = 1'b1; row_ready = 1'b1;
    tick();
    wr_en = 1'b0; start = 1'b0;
    check("launch clash wr_err", wr_err, 1);
    check("launch clash data", row_data, 0);

    // Reset after row 5 is accepted
    for (int r = 0; r < 6; r++) begin
      check("pre-reset idx", row_idx, r);
      tick();
    end
    check("pre-reset row6", row_idx, 6);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid reset valid", row_valid, 0);
    check("mid reset busy", busy, 0);
    check("mid reset done", done, 0);
    tick();
    check("mid reset no late done", done, 0);
    for (int r = 0; r < 16; r++) exp_rows[r] = '0;
    run_stream(2'd0);
    run_stream(2'd1);
    run_stream(2'd2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
